serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//  Parallel-in, serial-out transmitter (UART-style frame: 1 start, DATA_W data LSB-first, 1 stop).
//  Accepts a word through a valid/ready handshake and drives it bit-serially onto a single line.
//  Each bit is held for CLKS_PER_BIT clocks.
//  Source for the serial d-stream consumed by downstream latch/flip-flop capture logic.
// PARAMETERS
//  DATA_W        8   data bits per frame (>=1)
//  CLKS_PER_BIT  4   clocks each serial bit is held (>=1; 1 allowed)
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        reset, asynchronous, active-high
//  tx_valid  in   1        upstream has a word on tx_data
//  tx_data   in   DATA_W   word to send; sampled only on accept
//  tx_ready  out  1        block can accept a word (high only in IDLE)
//  tx_out    out  1        serial line; idles high
//  busy      out  1        frame in progress (START, DATA or STOP)
// BEHAVIOUR
//  Clock and reset
//  - One clock. rst asynchronous, active-high.
//  - While rst=1: state=IDLE, tx_out=1, busy=0, tx_ready=1, bit/clock counters=0, shift reg=0.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE
//  - IDLE: tx_out=1.
//    - Accept = tx_valid & tx_ready at a rising edge.
//    - On accept: latch tx_data into shift reg; go to START.
//  - START: tx_out=0 for CLKS_PER_BIT clocks; then DATA.
//  - DATA: tx_out = shift reg bit 0.
//    - Each bit is held CLKS_PER_BIT clocks, then the register shifts right.
//    - After DATA_W bits go to STOP.
//  - STOP: tx_out=1 for CLKS_PER_BIT clocks; then IDLE.
//  Timing
//  - tx_out and busy are registered.
//  - tx_ready is combinational from state: (state==IDLE).
//  - Start bit appears on tx_out the cycle after the accept edge.
//  - Frame length is exactly (DATA_W+2)*CLKS_PER_BIT clocks.
//  - IDLE lasts >=1 clock between frames.
//    - Back-to-back: with tx_valid held high, the next start bit begins 1 clock after the stop bit ends.
//  Boundary conditions
//  - tx_valid while busy: ignored, no queuing.
//  - tx_data changes after accept: no effect on the frame in flight.
//  - Clock counter width is clog2(CLKS_PER_BIT) (min 1); bit counter width is clog2(DATA_W) (min 1).
//    - Counters wrap to 0 at the end of each bit or frame.
//  - rst asserted mid-frame: frame abandoned at once, tx_out=1 asynchronously, nothing is resumed.
//  - tx_valid during the deassertion edge of rst: not accepted on that edge.
// TESTING (DATA_W=8, CLKS_PER_BIT=4 unless noted)
//  1 Reset: assert rst with tx_valid=1 -> tx_out=1, busy=0, tx_ready=1 immediately (no clock edge).
//  2 Single frame: send 8'hA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clks.
//    - busy high for exactly 40 clks, then tx_ready=1.
//  3 Back-to-back: tx_valid held high, 8'h00 then 8'hFF.
//    - Frame 2 starts 1 clk after frame 1's stop; 8'hFF frame = 0 then nine 1s.
//  4 Ignore while busy: pulse tx_valid with 8'h3C mid-frame, and change tx_data after accept.
//    - Transmitted frame unchanged; no second frame sent.
//  5 Reset mid-frame: assert rst during data bit 3 of 8'h55.
//    - tx_out=1 and busy=0 at once; after release a new 8'h81 frame is sent correctly.
//  6 CLKS_PER_BIT=1, DATA_W=4: send 4'b0110.
//    - tx_out = 0,0,1,1,0,1 on consecutive clks; busy for 6 clks.

Source files
------------

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//   Parallel-in, serial-out transmitter producing a UART-style frame:
//   one start bit (0), DATA_W data bits LSB-first, one stop bit (1).
//   Every bit is held on the line for CLKS_PER_BIT clocks.
//
// Parameters
//   DATA_W        data bits per frame (>=1)
//   CLKS_PER_BIT  clocks each serial bit is held (>=1)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   tx_valid  upstream has a word on tx_data
//   tx_data   word to send, sampled only when accepted
//   tx_ready  high only while idle (combinational from state)
//   tx_out    registered serial line, idles high
//   busy      registered, high while a frame is on the line
// -----------------------------------------------------------------------------
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy
);

   // Counter widths never drop below one bit so the degenerate
   // parameterisations (CLKS_PER_BIT=1, DATA_W=1) still elaborate.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     clk_cnt_q;
   logic [BW-1:0]     bit_cnt_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_d;
   logic              tx_out_q;
   logic              busy_q;

   // Shifted-down copy of the data register; its bit 0 is the next data
   // bit, which lets the registered line output be loaded one edge early.
   always_comb begin
      shift_d = shift_q >> 1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_out_q  <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               tx_out_q  <= 1'b1;
               busy_q    <= 1'b0;
               clk_cnt_q <= '0;
               bit_cnt_q <= '0;
               if (tx_valid) begin
                  // Outputs are registered, so the start bit is driven
                  // here to appear on the line the cycle after accept.
                  shift_q  <= tx_data;
                  state_q  <= START;
                  tx_out_q <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end

            START: begin
               if (clk_cnt_q == CLK_LAST) begin
                  clk_cnt_q <= '0;
                  state_q   <= DATA;
                  tx_out_q  <= shift_q[0];
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end

            DATA: begin
               if (clk_cnt_q == CLK_LAST) begin
                  clk_cnt_q <= '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_q <= '0;
                     state_q   <= STOP;
                     tx_out_q  <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     shift_q   <= shift_d;
                     tx_out_q  <= shift_d[0];
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end

            STOP: begin
               if (clk_cnt_q == CLK_LAST) begin
                  clk_cnt_q <= '0;
                  state_q   <= IDLE;
                  tx_out_q  <= 1'b1;
                  busy_q    <= 1'b0;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end

            default: begin
               state_q   <= IDLE;
               clk_cnt_q <= '0;
               bit_cnt_q <= '0;
               tx_out_q  <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready = (state_q == IDLE);
   assign tx_out   = tx_out_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

   logic       clk;
   logic       rst;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_out;
   logic       busy;

   logic       rst2;
   logic       tx_valid2;
   logic [3:0] tx_data2;
   logic       tx_ready2;
   logic       tx_out2;
   logic       busy2;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx_out   (tx_out),
      .busy     (busy)
   );

   serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_small (
      .clk      (clk),
      .rst      (rst2),
      .tx_valid (tx_valid2),
      .tx_data  (tx_data2),
      .tx_ready (tx_ready2),
      .tx_out   (tx_out2),
      .busy     (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected per-cycle line state for the main instance.
   typedef struct packed {
      logic o;
      logic b;
      logic r;
   } exp_t;
   exp_t exp_q[$];

   // Table vectors: data word and the literal line sequence, bit 0 first.
   typedef struct {
      logic [7:0] data;
      logic [9:0] bits;
   } vec_t;
   vec_t vecs[4];

   int check_cnt = 0;
   int pass_cnt  = 0;
   int item_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      check_cnt++;
      if (act !== req)
         $display("FAIL %s (item %0d): got %0h, required %0h", name, item_cnt, act, req);
      else
         pass_cnt++;
   endtask

   task automatic push_frame(input logic [9:0] bits);
      for (int i = 0; i < 10; i++)
         for (int c = 0; c < 4; c++)
            exp_q.push_back('{o: bits[i], b: 1'b1, r: 1'b0});
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{o: 1'b1, b: 1'b0, r: 1'b1});
   endtask

   // Pops and compares n cycles, one per falling edge; returns at the
   // falling edge following the last compared cycle.
   task automatic check_n(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("tx_out", {31'd0, tx_out}, {31'd0, e.o});
            chk("busy", {31'd0, busy}, {31'd0, e.b});
            chk("tx_ready", {31'd0, tx_ready}, {31'd0, e.r});
         end
         item_cnt++;
         @(negedge clk);
      end
   endtask

   // Presents a word, lets one rising edge accept it and returns at the
   // falling edge of the first start-bit cycle.
   task automatic drive_accept(input logic [7:0] d, input bit keep_valid);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      chk("ready_before_accept", {31'd0, tx_ready}, 32'd1);
      @(negedge clk);
      if (!keep_valid) tx_valid = 1'b0;
   endtask

   initial begin
      logic [5:0] pat;

      vecs[0] = '{data: 8'hA5, bits: 10'b1101001010};
      vecs[1] = '{data: 8'h3C, bits: 10'b1001111000};
      vecs[2] = '{data: 8'hC3, bits: 10'b1110000110};
      vecs[3] = '{data: 8'h01, bits: 10'b1000000010};

      rst       = 1'b1;
      tx_valid  = 1'b1;
      tx_data   = 8'hFF;
      rst2      = 1'b1;
      tx_valid2 = 1'b0;
      tx_data2  = 4'h0;

      // Reset held with tx_valid high: no frame may start.
      repeat (3) @(negedge clk);
      chk("reset_tx_out", {31'd0, tx_out}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
      rst      = 1'b0;
      rst2     = 1'b0;
      tx_valid = 1'b0;
      push_idle(3);
      check_n(3);

      // Table-driven single frames, each followed by idle cycles.
      for (int v = 0; v < 4; v++) begin
         drive_accept(vecs[v].data, 1'b0);
         push_frame(vecs[v].bits);
         push_idle(2);
         check_n(42);
         $display("frame %0d data=%02h checked", v, vecs[v].data);
      end

      // Back-to-back: valid held; data switches to FF after the first accept.
      drive_accept(8'h00, 1'b1);
      tx_data = 8'hFF;
      push_frame(10'b1000000000);
      push_idle(1);
      push_frame(10'b1111111110);
      push_idle(3);
      check_n(41);
      tx_valid = 1'b0;
      check_n(43);
      $display("back-to-back 00,FF checked");

      // Ignore while busy, and data change after accept.
      drive_accept(8'h3C, 1'b0);
      tx_data = 8'hC3;
      push_frame(10'b1001111000);
      push_idle(6);
      check_n(15);
      tx_valid = 1'b1;
      check_n(1);
      tx_valid = 1'b0;
      check_n(30);
      $display("ignore-while-busy 3C checked");

      // Reset during data bit 3 of 55 (cycles 17..20 of the frame).
      drive_accept(8'h55, 1'b0);
      push_frame(10'b1010101010);
      check_n(18);
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      #1;
      chk("midreset_tx_out", {31'd0, tx_out}, 32'd1);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      chk("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
      exp_q.delete();
      repeat (2) @(negedge clk);
      chk("inreset_tx_out", {31'd0, tx_out}, 32'd1);
      chk("inreset_busy", {31'd0, busy}, 32'd0);
      rst      = 1'b0;
      tx_valid = 1'b0;
      push_idle(2);
      check_n(2);
      drive_accept(8'h81, 1'b0);
      push_frame(10'b1100000010);
      push_idle(2);
      check_n(42);
      $display("reset mid-frame then 81 checked");

      // CLKS_PER_BIT=1, DATA_W=4 instance: 4'b0110 -> 0,0,1,1,0,1.
      pat = 6'b101100;
      @(negedge clk);
      tx_valid2 = 1'b1;
      tx_data2  = 4'b0110;
      chk("small_ready_before", {31'd0, tx_ready2}, 32'd1);
      @(negedge clk);
      tx_valid2 = 1'b0;
      tx_data2  = 4'b1001;
      for (int i = 0; i < 6; i++) begin
         chk("small_tx_out", {31'd0, tx_out2}, {31'd0, pat[i]});
         chk("small_busy", {31'd0, busy2}, 32'd1);
         @(negedge clk);
      end
      chk("small_end_busy", {31'd0, busy2}, 32'd0);
      chk("small_end_tx_out", {31'd0, tx_out2}, 32'd1);
      chk("small_end_ready", {31'd0, tx_ready2}, 32'd1);
      $display("small instance 0110 checked");

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
